// File: rtl/sfifo_param.sv
// Single-clock parametrised FIFO with occupancy count, programmable almost flags,
// overflow/underflow pulses and a selectable first-word-fall-through read port.
module sfifo_param #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 16,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  parameter  int FWFT      = 0,
  localparam int PTR_SIZE  = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic                rd_en,
  output logic [WIDTH-1:0]    rd_data,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic [PTR_SIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);

  localparam logic [PTR_SIZE:0]   CNT_MAX = (PTR_SIZE+1)'(DEPTH);
  localparam logic [PTR_SIZE:0]   CNT_ONE = (PTR_SIZE+1)'(1);
  localparam logic [PTR_SIZE:0]   AF_C    = (PTR_SIZE+1)'(AF_THRESH);
  localparam logic [PTR_SIZE:0]   AE_C    = (PTR_SIZE+1)'(AE_THRESH);
  localparam logic [PTR_SIZE-1:0] PTR_ONE = PTR_SIZE'(1);

  logic [WIDTH-1:0]    mem [DEPTH];
  logic [PTR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_SIZE:0]   count_q, count_d;
  logic                overflow_q, underflow_q;
  logic                wr_acc, rd_acc;

  // Flags decode only the registered count so they never depend on this cycle's requests.
  assign full         = (count_q == CNT_MAX);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  // Storage is deliberately left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_data = empty ? '0 : mem[rd_ptr_q];
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;
      always_ff @(posedge clk) begin
        if (rst)         rd_data_q <= '0;
        else if (rd_acc) rd_data_q <= mem[rd_ptr_q];
        else             rd_data_q <= '0;
      end
      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sfifo_param.sv
// Directed bench: one standard-mode and one FWFT instance, each scenario a task.
module tb_sfifo_param;
  logic       clk = 1'b0;
  logic       rst;
  logic       s_wr, s_rd, f_wr, f_rd;
  logic [7:0] s_wd, f_wd, s_rdd, f_rdd;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [4:0] s_cnt, f_cnt;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  sfifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(s_wr), .wr_data(s_wd), .rd_en(s_rd), .rd_data(s_rdd),
    .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
    .count(s_cnt), .overflow(s_ovf), .underflow(s_unf));

  sfifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr), .wr_data(f_wd), .rd_en(f_rd), .rd_data(f_rdd),
    .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
    .count(f_cnt), .overflow(f_ovf), .underflow(f_unf));

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    s_wr = 0; s_rd = 0; f_wr = 0; f_rd = 0;
  endtask

  task automatic test_reset();
    idle(); s_wd = 0; f_wd = 0; rst = 1;
    step(); step(); rst = 0;
    checks++;
    if ({s_cnt, s_empty, s_ae, s_full, s_af} !== {5'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_flags got cnt=%0d e=%b ae=%b f=%b af=%b exp cnt=0 e=1 ae=1 f=0 af=0",
                         s_cnt, s_empty, s_ae, s_full, s_af);
    end
    checks++;
    if ({s_rdd, s_ovf, s_unf} !== 10'd0) begin
      errors++; $display("FAIL reset_data got rd=%h ovf=%b unf=%b exp 00 0 0", s_rdd, s_ovf, s_unf);
    end
    step();
    checks++;
    if ({s_ovf, s_unf, f_ovf, f_unf, f_rdd, f_empty} !== {4'b0000, 8'h00, 1'b1}) begin
      errors++; $display("FAIL reset_idle got ovf=%b unf=%b fovf=%b funf=%b frd=%h fe=%b exp 0 0 0 0 00 1",
                         s_ovf, s_unf, f_ovf, f_unf, f_rdd, f_empty);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      s_wr = 1; s_wd = 8'(i); step();
      checks++;
      if ({s_cnt, s_full, s_af, s_ae, s_empty} !== {5'(i+1), (i+1) == 16, (i+1) >= 14, (i+1) <= 2, 1'b0}) begin
        errors++; $display("FAIL fill_%0d got cnt=%0d f=%b af=%b ae=%b e=%b", i, s_cnt, s_full, s_af, s_ae, s_empty);
      end
    end
    s_wd = 8'hEE; step();
    checks++;
    if ({s_ovf, s_cnt} !== {1'b1, 5'd16}) begin
      errors++; $display("FAIL overflow_pulse got ovf=%b cnt=%0d exp 1 16", s_ovf, s_cnt);
    end
    s_wr = 0; step();
    checks++;
    if ({s_ovf, s_cnt} !== {1'b0, 5'd16}) begin
      errors++; $display("FAIL overflow_clear got ovf=%b cnt=%0d exp 0 16", s_ovf, s_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      s_rd = 1; step();
      checks++;
      if ({s_rdd, s_cnt} !== {8'(i), 5'(15 - i)}) begin
        errors++; $display("FAIL drain_%0d got rd=%h cnt=%0d exp %h %0d", i, s_rdd, s_cnt, 8'(i), 15 - i);
      end
    end
    s_rd = 0; step();
    checks++;
    if ({s_rdd, s_empty, s_unf} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL drain_end got rd=%h e=%b unf=%b exp 00 1 0", s_rdd, s_empty, s_unf);
    end
    s_rd = 1; step(); s_rd = 0;
    checks++;
    if ({s_unf, s_cnt} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL underflow_pulse got unf=%b cnt=%0d exp 1 0", s_unf, s_cnt);
    end
    step();
    checks++;
    if (s_unf !== 1'b0) begin
      errors++; $display("FAIL underflow_clear got unf=%b exp 0", s_unf);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_rd;
    int wrs = 0, cyc = 0, ph;
    bit dw, dr;
    while (wrs < 40 || q.size() > 0) begin
      ph = cyc % 8;
      if (wrs >= 40)           begin dw = 0; dr = 1; end
      else if (q.size() <= 3)  begin dw = 1; dr = 0; end
      else if (q.size() >= 10) begin dw = 0; dr = 1; end
      else begin
        dw = (ph < 4) || (ph == 6);
        dr = (ph >= 3);
      end
      s_wr = dw; s_rd = dr; s_wd = 8'h40 + 8'(wrs);
      exp_rd = 8'h00;
      if (dr) exp_rd = q.pop_front();
      if (dw) begin q.push_back(s_wd); wrs++; end
      step(); cyc++;
      checks++;
      if ({s_rdd, s_cnt} !== {exp_rd, 5'(q.size())}) begin
        errors++; $display("FAIL wrap_c%0d got rd=%h cnt=%0d exp %h %0d", cyc, s_rdd, s_cnt, exp_rd, q.size());
      end
      if (cyc > 200) begin
        errors++; $display("FAIL wrap_budget got cyc=%0d exp <=200", cyc);
        break;
      end
    end
    idle();
  endtask

  task automatic test_simul();
    for (int i = 0; i < 16; i++) begin s_wr = 1; s_wd = 8'h80 + 8'(i); step(); end
    s_rd = 1; s_wd = 8'hFF; step();
    checks++;
    if ({s_cnt, s_ovf, s_rdd} !== {5'd15, 1'b1, 8'h80}) begin
      errors++; $display("FAIL simul_full got cnt=%0d ovf=%b rd=%h exp 15 1 80", s_cnt, s_ovf, s_rdd);
    end
    s_wr = 0;
    for (int i = 1; i < 16; i++) begin
      step();
      checks++;
      if (s_rdd !== 8'h80 + 8'(i)) begin
        errors++; $display("FAIL simul_drain_%0d got rd=%h exp %h", i, s_rdd, 8'h80 + 8'(i));
      end
    end
    s_wr = 1; s_rd = 1; s_wd = 8'h11; step();
    checks++;
    if ({s_cnt, s_unf, s_rdd} !== {5'd1, 1'b1, 8'h00}) begin
      errors++; $display("FAIL simul_empty got cnt=%0d unf=%b rd=%h exp 1 1 00", s_cnt, s_unf, s_rdd);
    end
    s_rd = 0;
    for (int i = 0; i < 4; i++) begin s_wd = 8'h12 + 8'(i); step(); end
    s_rd = 1; s_wd = 8'h16; step();
    checks++;
    if ({s_cnt, s_rdd, s_ovf, s_unf} !== {5'd5, 8'h11, 2'b00}) begin
      errors++; $display("FAIL simul_mid got cnt=%0d rd=%h ovf=%b unf=%b exp 5 11 0 0", s_cnt, s_rdd, s_ovf, s_unf);
    end
    s_wr = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (s_rdd !== 8'h12 + 8'(i)) begin
        errors++; $display("FAIL simul_tail_%0d got rd=%h exp %h", i, s_rdd, 8'h12 + 8'(i));
      end
    end
    idle(); step();
  endtask

  task automatic test_fwft();
    f_wr = 1; f_wd = 8'hA5; step(); f_wr = 0;
    checks++;
    if ({f_rdd, f_empty, f_cnt} !== {8'hA5, 1'b0, 5'd1}) begin
      errors++; $display("FAIL fwft_show got rd=%h e=%b cnt=%0d exp a5 0 1", f_rdd, f_empty, f_cnt);
    end
    step();
    checks++;
    if (f_rdd !== 8'hA5) begin
      errors++; $display("FAIL fwft_hold got rd=%h exp a5", f_rdd);
    end
    f_rd = 1; step(); f_rd = 0;
    checks++;
    if ({f_rdd, f_empty} !== {8'h00, 1'b1}) begin
      errors++; $display("FAIL fwft_pop got rd=%h e=%b exp 00 1", f_rdd, f_empty);
    end
    f_wr = 1; f_wd = 8'h01; step(); f_wd = 8'h02; step(); f_wr = 0;
    checks++;
    if ({f_rdd, f_cnt} !== {8'h01, 5'd2}) begin
      errors++; $display("FAIL fwft_two got rd=%h cnt=%0d exp 01 2", f_rdd, f_cnt);
    end
    f_rd = 1; step();
    checks++;
    if (f_rdd !== 8'h02) begin
      errors++; $display("FAIL fwft_next got rd=%h exp 02", f_rdd);
    end
    step(); f_rd = 0;
    checks++;
    if ({f_rdd, f_empty, f_unf} !== {8'h00, 1'b1, 1'b0}) begin
      errors++; $display("FAIL fwft_end got rd=%h e=%b unf=%b exp 00 1 0", f_rdd, f_empty, f_unf);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) begin s_wr = 1; s_wd = 8'hC0 + 8'(i); step(); end
    s_wr = 0;
    checks++;
    if (s_cnt !== 5'd9) begin
      errors++; $display("FAIL rstmid_pre got cnt=%0d exp 9", s_cnt);
    end
    rst = 1; step(); rst = 0;
    checks++;
    if ({s_cnt, s_empty, s_rdd, s_ovf, s_unf} !== {5'd0, 1'b1, 8'h00, 2'b00}) begin
      errors++; $display("FAIL rstmid_post got cnt=%0d e=%b rd=%h ovf=%b unf=%b exp 0 1 00 0 0",
                         s_cnt, s_empty, s_rdd, s_ovf, s_unf);
    end
    s_wr = 1; s_wd = 8'h3C; step(); s_wr = 0;
    s_rd = 1; step(); s_rd = 0;
    checks++;
    if ({s_rdd, s_empty} !== {8'h3C, 1'b1}) begin
      errors++; $display("FAIL rstmid_read got rd=%h e=%b exp 3c 1", s_rdd, s_empty);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simul();
    test_fwft();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sfifo_param.md
# sfifo_param

Single-clock, parametrised synchronous FIFO: the single-domain counterpart of the team's asynchronous FIFO for blocks that share one clock. It generalises width and depth and adds an occupancy count, programmable almost-full/almost-empty flags, sticky-free overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between a producer and consumer in the same clock domain, e.g. behind a CDC stage or in front of a serialiser.

## Interface
- WIDTH, 8: data width in bits, >= 1.
- DEPTH, 16: number of entries; power of two, >= 2.
- AF_THRESH, DEPTH-2: almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH.
- AE_THRESH, 2: almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- PTR_SIZE (localparam): log2(DEPTH).

- clk  input  1  single clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- wr_data  input  WIDTH  write data.
- rd_en  input  1  read request (pop).
- rd_data  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AF_THRESH.
- almost_empty  output  1  count <= AE_THRESH.
- count  output  PTR_SIZE+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: write attempted while full.
- underflow  output  1  one-cycle pulse: read attempted while empty.

## Operation
- Reset is synchronous and active-high: on a rising clk edge with rst=1, wr_ptr, rd_ptr, count, rd_data, overflow and underflow are all cleared to 0. Outputs after reset: empty=1, almost_empty=1, full=0, almost_full=0, count=0, rd_data=0. The memory array is not reset.
- A write is accepted iff wr_en && !full. Accepted write: mem[wr_ptr] <= wr_data, then wr_ptr increments.
- A read is accepted iff rd_en && !empty. Accepted read: rd_ptr increments.
- Pointers are PTR_SIZE bits wide and wrap from DEPTH-1 to 0 naturally.
- count update: +1 for a write only, -1 for a read only, unchanged when both or neither are accepted.
- Full with simultaneous wr_en and rd_en: only the read is accepted; count goes DEPTH -> DEPTH-1; overflow pulses.
- Empty with simultaneous wr_en and rd_en: only the write is accepted; count goes 0 -> 1; underflow pulses.
- Flag derivation: full, empty, almost_full and almost_empty are decoded from the registered count only, so they are glitch-free and independent of the current cycle's wr_en/rd_en.
- overflow: registered pulse. overflow <= wr_en && full, evaluated with the pre-edge full. underflow is the same form using rd_en && empty. Neither is sticky.
- FWFT=0 (standard mode):
  - An accepted read registers mem[rd_ptr] into rd_data.
  - In any cycle with no accepted read, rd_data <= 0.
- FWFT=1:
  - rd_data = mem[rd_ptr] combinationally whenever !empty; it is forced to 0 when empty.
  - rd_en acknowledges and pops the displayed word.

## Timing
- Write to flag: a write accepted at edge N updates count, empty and almost_* at edge N. These are visible in cycle N+1.
- Standard mode read latency: a read accepted at edge N presents its data on rd_data in cycle N+1, valid for one cycle.
- FWFT latency: a word written into an empty FIFO at edge N appears on rd_data, with empty=0, in cycle N+1.
- Back-to-back: one write and one read can be sustained every cycle indefinitely with no bubbles.
- Reset mid-operation: the FIFO is empty in the cycle after the reset edge. Stored data is discarded, and no overflow or underflow pulse is generated for the reset cycle.

## Test plan
- Reset then idle: assert rst for 2 cycles -> count=0, empty=1, almost_empty=1, full=0, rd_data=0, no error pulses.
- Fill/drain, FWFT=0, DEPTH=16:
  - Write 0x00..0x0F -> full=1 after the 16th edge; almost_full=1 from count 14.
  - 17th write -> overflow=1 for exactly 1 cycle, count stays 16.
  - Read 16 times -> rd_data = 0x00..0x0F, each one cycle after its accepted read; empty=1 at end.
  - One further read -> underflow=1 for 1 cycle.
- Wrap-around: 40 writes interleaved with reads, keeping count between 3 and 10 -> data order preserved across pointer wrap; count matches the scoreboard every cycle.
- Simultaneous events:
  - At count=16, wr_en=rd_en=1 -> count 15, overflow pulse, oldest word read.
  - At count=0, wr_en=rd_en=1 -> count 1, underflow pulse.
  - At count=5, wr_en=rd_en=1 -> count stays 5.
- FWFT=1: write 0xA5 into an empty FIFO -> rd_data=0xA5 and empty=0 in the next cycle, before any rd_en. Pop -> empty=1, rd_data=0.
- Reset mid-operation: with count=9, assert rst for 1 cycle -> next cycle count=0, empty=1. A subsequent write of 0x3C is read back first.
